// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : program_loader
//  Description : Write-side loader for the stack core instruction memory.
//                Takes 16-bit program words from the host on a valid/ready
//                handshake and writes them sequentially into inst_mem. The
//                core is held in reset while the image loads. go is raised
//                once the image is complete.
//  Option      : LOADER_CHECKSUM_EN - when defined, one extra beat after the
//                in_last beat carries the XOR of all written words. A
//                mismatch ends in the error state.
//  Ports       : clk, async_reset (async, active-high), start,
//                in_valid/in_ready/in_data/in_last (host stream),
//                mem_we/mem_addr/mem_din (inst_mem write port),
//                core_hold, go, busy, error, word_count (status)
//  Revision    : 1.0 - initial release
// ============================================================================
module program_loader #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 16,
    parameter int DEPTH      = 1024,
    parameter int START_ADDR = 0
) (
    input  logic              clk,
    input  logic              async_reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              core_hold,
    output logic              go,
    output logic              busy,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHECK = 3'd2;
`endif
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    localparam logic [ADDR_W-1:0] c_start = START_ADDR[ADDR_W-1:0];
    localparam logic [ADDR_W:0]   c_depth = DEPTH[ADDR_W:0];

    logic [2:0] r_state;
    logic [2:0] w_next_state;

    logic w_accept;
    logic w_overrun;
    logic w_write;
    logic w_load_entry;
    logic w_ready_next;
    logic w_run_next;
    logic w_err_next;

`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] r_csum;
`endif

    assign w_accept  = in_valid && in_ready;
    assign w_overrun = (word_count == c_depth);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_RUN, S_ERR: begin
                if (start) begin
                    w_next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_accept) begin
                    // Overrun wins over in_last: a word beyond DEPTH is never written.
                    if (w_overrun) begin
                        w_next_state = S_ERR;
                    end else if (in_last) begin
`ifdef LOADER_CHECKSUM_EN
                        w_next_state = S_CHECK;
`else
                        w_next_state = S_RUN;
`endif
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (w_accept) begin
                    w_next_state = (in_data == r_csum) ? S_RUN : S_ERR;
                end
            end
`endif
            default: w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode (values registered below)
    // ------------------------------------------------------------------
    always_comb begin
        w_write      = w_accept && (r_state == S_LOAD) && !w_overrun;
        w_load_entry = (w_next_state == S_LOAD) && (r_state != S_LOAD);
`ifdef LOADER_CHECKSUM_EN
        w_ready_next = (w_next_state == S_LOAD) || (w_next_state == S_CHECK);
`else
        w_ready_next = (w_next_state == S_LOAD);
`endif
        // go waits one cycle inside RUN so the final write pulse has completed.
        w_run_next   = (w_next_state == S_RUN) && (r_state == S_RUN);
        w_err_next   = (w_next_state == S_ERR);
    end

    // ------------------------------------------------------------------
    // Registered outputs and datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            go         <= 1'b0;
            core_hold  <= 1'b1;
            error      <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= c_start;
            mem_din    <= '0;
            word_count <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_csum     <= '0;
`endif
        end else begin
            in_ready  <= w_ready_next;
            busy      <= w_ready_next;
            go        <= w_run_next;
            core_hold <= !w_run_next;
            error     <= w_err_next;
            mem_we    <= w_write;
            if (w_write) begin
                mem_din <= in_data;
            end
            if (w_load_entry) begin
                mem_addr   <= c_start;
                word_count <= '0;
`ifdef LOADER_CHECKSUM_EN
                r_csum     <= '0;
`endif
            end else begin
                // mem_addr holds the write address during the pulse, then advances.
                if (mem_we) begin
                    mem_addr <= mem_addr + 1'b1;
                end
                if (w_write) begin
                    word_count <= word_count + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    r_csum     <= r_csum ^ in_data;
`endif
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_program_loader
//  Description : Directed self-checking bench for program_loader. A default
//                instance and a DEPTH=4 instance share the input stimulus.
//                The checksum scenario is compiled when LOADER_CHECKSUM_EN is
//                defined; otherwise the no-checksum end of load is exercised.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_program_loader;

    logic        clk = 1'b0;
    logic        async_reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [15:0] in_data = 16'h0;

    logic        in_ready, mem_we, core_hold, go, busy, error;
    logic [9:0]  mem_addr;
    logic [15:0] mem_din;
    logic [10:0] word_count;

    logic        in_ready_4, mem_we_4, core_hold_4, go_4, busy_4, error_4;
    logic [9:0]  mem_addr_4;
    logic [15:0] mem_din_4;
    logic [10:0] word_count_4;

    int n_vec = 0;
    int n_err = 0;

    logic [9:0]  log_a[$];
    logic [15:0] log_d[$];
    logic [9:0]  log4_a[$];
    logic [15:0] log4_d[$];

    always #5 clk = ~clk;

    program_loader dut (
        .clk(clk), .async_reset(async_reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .core_hold(core_hold), .go(go), .busy(busy), .error(error), .word_count(word_count)
    );

    program_loader #(.DEPTH(4)) dut4 (
        .clk(clk), .async_reset(async_reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready_4), .in_data(in_data), .in_last(in_last),
        .mem_we(mem_we_4), .mem_addr(mem_addr_4), .mem_din(mem_din_4),
        .core_hold(core_hold_4), .go(go_4), .busy(busy_4), .error(error_4), .word_count(word_count_4)
    );

    // Memory-side view: a write lands at the edge that ends the mem_we cycle.
    always @(posedge clk) begin
        if (mem_we === 1'b1) begin
            log_a.push_back(mem_addr);
            log_d.push_back(mem_din);
        end
        if (mem_we_4 === 1'b1) begin
            log4_a.push_back(mem_addr_4);
            log4_d.push_back(mem_din_4);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        log_a.delete(); log_d.delete(); log4_a.delete(); log4_d.delete();
    endtask

    task automatic apply_reset();
        start = 0; in_valid = 0; in_last = 0; in_data = 0;
        async_reset = 1;
        tick(); tick();
        async_reset = 0;
        tick();
        clear_logs();
    endtask

    task automatic pulse_start();
        start = 1;
        tick();
        start = 0;
    endtask

    // Present one beat until accepted (bounded). ok=0 on timeout.
    task automatic send(input logic [15:0] d, input logic last, input bit use4, output bit ok);
        in_valid = 1; in_data = d; in_last = last; ok = 0;
        for (int i = 0; i < 16; i++) begin
            if ((use4 ? in_ready_4 : in_ready) === 1'b1) begin
                ok = 1;
                tick();
                break;
            end
            tick();
        end
        in_valid = 0; in_last = 0; in_data = 16'h0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_vec++; if (in_ready !== 1'b0)     begin n_err++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        n_vec++; if (mem_we !== 1'b0)       begin n_err++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
        n_vec++; if (mem_addr !== 10'd0)    begin n_err++; $display("FAIL reset_mem_addr got %0d want 0", mem_addr); end
        n_vec++; if (mem_din !== 16'h0)     begin n_err++; $display("FAIL reset_mem_din got %h want 0000", mem_din); end
        n_vec++; if (core_hold !== 1'b1)    begin n_err++; $display("FAIL reset_core_hold got %b want 1", core_hold); end
        n_vec++; if (go !== 1'b0)           begin n_err++; $display("FAIL reset_go got %b want 0", go); end
        n_vec++; if (busy !== 1'b0)         begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_vec++; if (error !== 1'b0)        begin n_err++; $display("FAIL reset_error got %b want 0", error); end
        n_vec++; if (word_count !== 11'd0)  begin n_err++; $display("FAIL reset_word_count got %0d want 0", word_count); end
    endtask

    task automatic test_basic_load();
        logic [15:0] w[3] = '{16'h1111, 16'h2222, 16'h3333};
        bit ok;
        clear_logs();
        pulse_start();
        n_vec++; if (in_ready !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL basic_load_entry got ready=%b busy=%b want 1/1", in_ready, busy); end
        n_vec++; if (core_hold !== 1'b1) begin n_err++; $display("FAIL basic_hold_in_load got %b want 1", core_hold); end
        for (int i = 0; i < 3; i++) begin
            send(w[i], (i == 2), 0, ok);
            n_vec++; if (!ok) begin n_err++; $display("FAIL basic_accept_%0d timeout got no ready want accepted", i); end
            n_vec++;
            if (mem_we !== 1'b1 || mem_addr !== 10'(i) || mem_din !== w[i] || word_count !== 11'(i + 1)) begin
                n_err++;
                $display("FAIL basic_write_%0d got we=%b addr=%0d din=%h cnt=%0d want 1/%0d/%h/%0d",
                         i, mem_we, mem_addr, mem_din, word_count, i, w[i], i + 1);
            end
        end
        n_vec++; if (go !== 1'b0 || in_ready !== 1'b0) begin n_err++; $display("FAIL basic_go_early got go=%b ready=%b want 0/0", go, in_ready); end
        tick();
        n_vec++; if (go !== 1'b1 || core_hold !== 1'b0 || mem_we !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL basic_go got go=%b hold=%b we=%b busy=%b want 1/0/0/0", go, core_hold, mem_we, busy);
        end
        tick();
        n_vec++; if (log_a.size() != 3) begin n_err++; $display("FAIL basic_write_count got %0d want 3", log_a.size()); end
        else for (int i = 0; i < 3; i++) begin
            n_vec++; if (log_a[i] !== 10'(i) || log_d[i] !== w[i]) begin
                n_err++; $display("FAIL basic_mem_%0d got %0d:%h want %0d:%h", i, log_a[i], log_d[i], i, w[i]);
            end
        end
    endtask

    task automatic test_toggle_valid();
        logic [15:0] w[3] = '{16'h1111, 16'h2222, 16'h3333};
        bit ok;
        clear_logs();
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            send(w[i], (i == 2), 0, ok);
            n_vec++; if (!ok) begin n_err++; $display("FAIL toggle_accept_%0d timeout got no ready want accepted", i); end
            // idle cycle with junk on data/last that must be ignored
            in_valid = 0; in_data = 16'hDEAD; in_last = 1;
            tick();
            in_data = 16'h0; in_last = 0;
        end
        n_vec++; if (go !== 1'b1 || word_count !== 11'd3) begin n_err++; $display("FAIL toggle_go got go=%b cnt=%0d want 1/3", go, word_count); end
        n_vec++; if (log_a.size() != 3) begin n_err++; $display("FAIL toggle_write_count got %0d want 3", log_a.size()); end
        else for (int i = 0; i < 3; i++) begin
            n_vec++; if (log_a[i] !== 10'(i) || log_d[i] !== w[i]) begin
                n_err++; $display("FAIL toggle_mem_%0d got %0d:%h want %0d:%h", i, log_a[i], log_d[i], i, w[i]);
            end
        end
    endtask

    task automatic test_overrun();
        bit ok;
        apply_reset();
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            send(16'hA000 + 16'(i), 1'b0, 1, ok);
            n_vec++; if (!ok) begin n_err++; $display("FAIL overrun_accept_%0d timeout got no ready want accepted", i); end
        end
        n_vec++; if (error_4 !== 1'b1 || go_4 !== 1'b0 || in_ready_4 !== 1'b0 || core_hold_4 !== 1'b1) begin
            n_err++; $display("FAIL overrun_status got err=%b go=%b ready=%b hold=%b want 1/0/0/1", error_4, go_4, in_ready_4, core_hold_4);
        end
        n_vec++; if (word_count_4 !== 11'd4 || mem_we_4 !== 1'b0 || busy_4 !== 1'b0) begin
            n_err++; $display("FAIL overrun_count got cnt=%0d we=%b busy=%b want 4/0/0", word_count_4, mem_we_4, busy_4);
        end
        tick(); tick();
        n_vec++; if (error_4 !== 1'b1) begin n_err++; $display("FAIL overrun_sticky got %b want 1", error_4); end
        n_vec++; if (log4_a.size() != 4) begin n_err++; $display("FAIL overrun_write_count got %0d want 4", log4_a.size()); end
        else for (int i = 0; i < 4; i++) begin
            n_vec++; if (log4_a[i] !== 10'(i) || log4_d[i] !== 16'hA000 + 16'(i)) begin
                n_err++; $display("FAIL overrun_mem_%0d got %0d:%h want %0d:%h", i, log4_a[i], log4_d[i], i, 16'hA000 + 16'(i));
            end
        end
        apply_reset();
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        logic [15:0] sums[2] = '{16'h0FF0, 16'h0FF1};
        bit ok;
        for (int r = 0; r < 2; r++) begin
            clear_logs();
            pulse_start();
            send(16'h00F0, 1'b0, 0, ok);
            send(16'h0F00, 1'b1, 0, ok);
            n_vec++; if (in_ready !== 1'b1 || busy !== 1'b1 || go !== 1'b0) begin
                n_err++; $display("FAIL csum_check_state_%0d got ready=%b busy=%b go=%b want 1/1/0", r, in_ready, busy, go);
            end
            send(sums[r], 1'b0, 0, ok);
            n_vec++; if (!ok || mem_we !== 1'b0) begin n_err++; $display("FAIL csum_beat_%0d got ok=%b we=%b want 1/0", r, ok, mem_we); end
            tick();
            if (r == 0) begin
                n_vec++; if (go !== 1'b1 || core_hold !== 1'b0 || error !== 1'b0) begin
                    n_err++; $display("FAIL csum_match got go=%b hold=%b err=%b want 1/0/0", go, core_hold, error);
                end
            end else begin
                n_vec++; if (go !== 1'b0 || core_hold !== 1'b1 || error !== 1'b1) begin
                    n_err++; $display("FAIL csum_mismatch got go=%b hold=%b err=%b want 0/1/1", go, core_hold, error);
                end
            end
            n_vec++; if (log_a.size() != 2 || word_count !== 11'd2) begin
                n_err++; $display("FAIL csum_writes_%0d got %0d cnt=%0d want 2/2", r, log_a.size(), word_count);
            end
        end
    endtask
`else
    task automatic test_no_checksum();
        bit ok;
        clear_logs();
        pulse_start();
        send(16'h4242, 1'b1, 0, ok);
        n_vec++; if (!ok || mem_we !== 1'b1 || mem_addr !== 10'd0 || in_ready !== 1'b0) begin
            n_err++; $display("FAIL single_word got ok=%b we=%b addr=%0d ready=%b want 1/1/0/0", ok, mem_we, mem_addr, in_ready);
        end
        tick();
        n_vec++; if (go !== 1'b1) begin n_err++; $display("FAIL single_word_go got %b want 1", go); end
        in_valid = 1; in_data = 16'hBEEF;
        tick(); tick(); tick();
        in_valid = 0; in_data = 16'h0;
        n_vec++; if (log_a.size() != 1 || go !== 1'b1 || word_count !== 11'd1) begin
            n_err++; $display("FAIL extra_beat got writes=%0d go=%b cnt=%0d want 1/1/1", log_a.size(), go, word_count);
        end
    endtask
`endif

    task automatic test_async_reset();
        bit ok;
        pulse_start();
        send(16'h5A01, 1'b0, 0, ok);
        send(16'h5A02, 1'b0, 0, ok);
        n_vec++; if (mem_we !== 1'b1 || word_count !== 11'd2) begin n_err++; $display("FAIL areset_pre got we=%b cnt=%0d want 1/2", mem_we, word_count); end
        #2;
        async_reset = 1;
        #1;
        n_vec++;
        if (in_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 10'd0 || mem_din !== 16'h0 || core_hold !== 1'b1 ||
            go !== 1'b0 || busy !== 1'b0 || error !== 1'b0 || word_count !== 11'd0) begin
            n_err++;
            $display("FAIL areset_outputs got rdy=%b we=%b addr=%0d din=%h hold=%b go=%b busy=%b err=%b cnt=%0d want 0/0/0/0000/1/0/0/0/0",
                     in_ready, mem_we, mem_addr, mem_din, core_hold, go, busy, error, word_count);
        end
        tick();
        async_reset = 0;
        tick();
        clear_logs();
        pulse_start();
        send(16'h6601, 1'b0, 0, ok);
        send(16'h6602, 1'b1, 0, ok);
        tick(); tick();
        n_vec++; if (log_a.size() != 2) begin n_err++; $display("FAIL areset_reload_count got %0d want 2", log_a.size()); end
        else begin
            n_vec++; if (log_a[0] !== 10'd0 || log_d[0] !== 16'h6601 || log_a[1] !== 10'd1 || log_d[1] !== 16'h6602) begin
                n_err++; $display("FAIL areset_reload got %0d:%h %0d:%h want 0:6601 1:6602", log_a[0], log_d[0], log_a[1], log_d[1]);
            end
        end
        n_vec++; if (go !== 1'b1) begin n_err++; $display("FAIL areset_reload_go got %b want 1", go); end
    endtask

    task automatic test_restart_in_run();
        bit ok;
        n_vec++; if (go !== 1'b1) begin n_err++; $display("FAIL restart_pre_go got %b want 1", go); end
        clear_logs();
        pulse_start();
        n_vec++; if (go !== 1'b0 || core_hold !== 1'b1 || in_ready !== 1'b1 || word_count !== 11'd0 || mem_addr !== 10'd0) begin
            n_err++; $display("FAIL restart_drop got go=%b hold=%b rdy=%b cnt=%0d addr=%0d want 0/1/1/0/0",
                              go, core_hold, in_ready, word_count, mem_addr);
        end
        // start while loading is ignored
        pulse_start();
        send(16'h7777, 1'b1, 0, ok);
        n_vec++; if (!ok || mem_we !== 1'b1 || mem_addr !== 10'd0 || mem_din !== 16'h7777 || word_count !== 11'd1) begin
            n_err++; $display("FAIL restart_write got ok=%b we=%b addr=%0d din=%h cnt=%0d want 1/1/0/7777/1",
                              ok, mem_we, mem_addr, mem_din, word_count);
        end
        tick();
        n_vec++; if (go !== 1'b1 || core_hold !== 1'b0) begin n_err++; $display("FAIL restart_go got go=%b hold=%b want 1/0", go, core_hold); end
        tick();
        n_vec++; if (log_a.size() != 1) begin n_err++; $display("FAIL restart_write_count got %0d want 1", log_a.size()); end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_toggle_valid();
        test_overrun();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`else
        test_no_checksum();
`endif
        test_async_reset();
        test_restart_in_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
